// File: rtl/npc_pkg.sv
// Shared npc core definitions: GPR geometry, the a0 index and the
// register-file sequencing state encoding.
package npc_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int XLEN       = 64;
  localparam int GPR_A0     = 10;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } gpr_state_e;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits for in-flight producers; an alloc outranks a
// same-cycle writeback to the same index because the newer producer owns it.
module gpr_scoreboard #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic                          alloc_en,
  input  logic [ADDR_WIDTH-1:0]         alloc_addr,
  output logic [(1<<ADDR_WIDTH)-1:0]    pending
);

  logic [(1<<ADDR_WIDTH)-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (run) begin
      if (wen && waddr != '0) pending_nxt[waddr] = 1'b0;
      // Applied after the clear so a colliding alloc leaves the bit set.
      if (alloc_en && alloc_addr != '0) pending_nxt[alloc_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

endmodule

// File: rtl/gpr_file.sv
// Integer register file: self-clearing after reset, NR_READ combinational
// read ports with optional write bypass, pending-bit busy flags, debug port.
module gpr_file
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_W,
  parameter int DATA_WIDTH = XLEN,
  parameter int NR_READ    = 2,
  parameter int BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ready,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          alloc_en,
  input  logic [ADDR_WIDTH-1:0]         alloc_addr,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic [NR_READ-1:0]            rbusy,
  input  logic [ADDR_WIDTH-1:0]         dbg_addr,
  output logic [DATA_WIDTH-1:0]         dbg_data,
  output gpr_state_e                    dbg_state
);

  localparam int N = 1 << ADDR_WIDTH;

  gpr_state_e            state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [DATA_WIDTH-1:0] rf [N];
  logic [N-1:0]          pending;
  logic                  run;

  assign run       = (state == RUN);
  assign ready     = run;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      rf[clr_idx] <= '0;
      clr_idx     <= clr_idx + 1'b1;
      if (clr_idx == ADDR_WIDTH'(N - 1)) state <= RUN;
    end else if (wen && waddr != '0) begin
      rf[waddr] <= wdata;
    end
  end

  gpr_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .wen        (wen),
    .waddr      (waddr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .pending    (pending)
  );

  always_comb begin : read_ports
    logic [ADDR_WIDTH-1:0] ra;
    ra    = '0;
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NR_READ; k++) begin
      ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (run && ra != '0) begin
        if (BYPASS != 0 && wen && waddr == ra) begin
          rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata;
        end else begin
          rdata[k*DATA_WIDTH +: DATA_WIDTH] = rf[ra];
          rbusy[k]                          = pending[ra];
        end
      end
    end
  end

  // rf[0] is zeroed by the sweep and never written afterwards.
  assign dbg_data = run ? rf[dbg_addr] : '0;

endmodule

// File: tb/tb_gpr_file.sv
// Randomized bench for gpr_file: a bypassing and a non-bypassing instance
// share stimulus and are compared against an array-based reference model.
module tb_gpr_file;
  import npc_pkg::*;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 2;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          alloc_en = 1'b0;
  logic [AW-1:0] alloc_addr = '0;
  logic [AW-1:0] ra [NR];
  logic [NR*AW-1:0] raddr;
  logic [AW-1:0] dbg_addr = '0;

  logic             ready_b, ready_n;
  logic [NR*DW-1:0] rdata_b, rdata_n;
  logic [NR-1:0]    rbusy_b, rbusy_n;
  logic [DW-1:0]    dbg_b, dbg_n;
  gpr_state_e       state_b, state_n;

  assign raddr = {ra[1], ra[0]};

  always #5 clk = ~clk;

  gpr_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ready(ready_b), .wen(wen), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .raddr(raddr), .rdata(rdata_b),
    .rbusy(rbusy_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b), .dbg_state(state_b)
  );

  gpr_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .ready(ready_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .raddr(raddr), .rdata(rdata_n),
    .rbusy(rbusy_n), .dbg_addr(dbg_addr), .dbg_data(dbg_n), .dbg_state(state_n)
  );

  // Reference model: architectural contents, pending set, sweep countdown.
  logic [DW-1:0] m_rf [N];
  bit            m_pend [N];
  bit            m_ready;
  int            m_left;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_ready = 0;
      m_left  = N;
      for (int i = 0; i < N; i++) m_pend[i] = 0;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        for (int i = 0; i < N; i++) m_rf[i] = '0;
      end
    end else begin
      if (wen && waddr != 0) begin
        m_rf[waddr]   = wdata;
        m_pend[waddr] = 0;
      end
      if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1;
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (!m_ready || a == 0) return '0;
    if (byp && wen && waddr == a) return wdata;
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (!m_ready || a == 0) return 1'b0;
    if (byp && wen && waddr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic probe();
    @(negedge clk);
    check("ready_b", {63'd0, ready_b}, {63'd0, m_ready});
    check("ready_n", {63'd0, ready_n}, {63'd0, m_ready});
    check("dbg_b", dbg_b, m_ready ? m_rf[dbg_addr] : '0);
    check("dbg_n", dbg_n, m_ready ? m_rf[dbg_addr] : '0);
    for (int k = 0; k < NR; k++) begin
      check($sformatf("rdata_b%0d", k), rdata_b[k*DW +: DW], exp_data(ra[k], 1));
      check($sformatf("rdata_n%0d", k), rdata_n[k*DW +: DW], exp_data(ra[k], 0));
      check($sformatf("rbusy_b%0d", k), {63'd0, rbusy_b[k]}, {63'd0, exp_busy(ra[k], 1)});
      check($sformatf("rbusy_n%0d", k), {63'd0, rbusy_n[k]}, {63'd0, exp_busy(ra[k], 0)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    probe();
    tick();
  endtask

  task automatic idle();
    wen = 0; alloc_en = 0; rst = 0;
  endtask

  task automatic rand_ops();
    wen        = 1'($urandom_range(0, 1));
    waddr      = AW'($urandom_range(0, 7));
    wdata      = {$urandom, $urandom};
    alloc_en   = 1'($urandom_range(0, 1));
    alloc_addr = AW'($urandom_range(0, 7));
  endtask

  // Sweep length check with random write/alloc traffic that must be ignored.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    rst = 0;
    while (!ready_b && n < 100) begin
      rand_ops();
      dbg_addr = AW'($urandom_range(0, N - 1));
      cycle();
      n++;
    end
    check(tag, 64'(n), 64'd32);
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    ra[0] = '0; ra[1] = '0;
    // Power-up: state is unknown until the first reset edge.
    tick();
    rst = 0;

    // 1. reset sweep and full debug scan
    wait_ready("sweep_len");
    for (int i = 0; i < N; i++) begin
      dbg_addr = AW'(i);
      cycle();
    end

    // 2. write/read and x0
    wen = 1; waddr = 5; wdata = 64'hDEAD_BEEF; cycle();
    waddr = 0; wdata = 64'h1234; cycle();
    waddr = 10; wdata = 64'h7; cycle();
    idle(); ra[0] = 5; ra[1] = 0; dbg_addr = AW'(GPR_A0);
    probe();
    check("r5_read", rdata_b[0 +: DW], 64'hDEAD_BEEF);
    check("x0_read", rdata_b[DW +: DW], 64'h0);
    check("a0_dbg", dbg_b, 64'h7);
    tick();

    // 3. bypass vs no bypass
    wen = 1; waddr = 7; wdata = 64'hAA; ra[1] = 7;
    probe();
    check("byp_same", rdata_b[DW +: DW], 64'hAA);
    check("nobyp_same", rdata_n[DW +: DW], 64'h0);
    tick();
    idle();
    probe();
    check("nobyp_next", rdata_n[DW +: DW], 64'hAA);
    tick();

    // 4. scoreboard
    alloc_en = 1; alloc_addr = 3; cycle();
    idle(); ra[0] = 3; ra[1] = 3;
    probe();
    check("busy_r3", {62'd0, rbusy_b}, 64'h3);
    tick();
    wen = 1; waddr = 3; wdata = 64'h55;
    probe();
    check("busy_byp", {63'd0, rbusy_b[0]}, 64'h0);
    check("busy_nobyp", {63'd0, rbusy_n[0]}, 64'h1);
    tick();
    idle();
    probe();
    check("r3_done", {62'd0, rbusy_n}, 64'h0);
    check("r3_data", rdata_n[0 +: DW], 64'h55);
    tick();

    // 5. alloc/write collision
    wen = 1; waddr = 4; wdata = 64'h9; alloc_en = 1; alloc_addr = 4; cycle();
    idle(); ra[0] = 4; dbg_addr = 4;
    probe();
    check("coll_busy", {63'd0, rbusy_b[0]}, 64'h1);
    check("coll_data", dbg_b, 64'h9);
    tick();

    // 6. reset mid-operation, then restart mid-sweep
    wen = 1; waddr = 8; wdata = 64'h1; alloc_en = 1; alloc_addr = 9; cycle();
    do_reset();
    ra[0] = 8; ra[1] = 9;
    wait_ready("sweep_after_run");
    ra[0] = 8; ra[1] = 9;
    probe();
    check("r8_cleared", rdata_b[0 +: DW], 64'h0);
    check("r9_unpend", {63'd0, rbusy_n[1]}, 64'h0);
    tick();
    do_reset();
    for (int i = 0; i < 20; i++) cycle();
    do_reset();
    wait_ready("sweep_restart");

    // Random traffic with rare resets
    for (int i = 0; i < 3000; i++) begin
      rand_ops();
      if ($urandom_range(0, 3) == 0) waddr = AW'($urandom_range(0, N - 1));
      ra[0]    = AW'($urandom_range(0, 7));
      ra[1]    = AW'($urandom_range(0, 7));
      dbg_addr = AW'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 499) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
Next-generation integer register file for the npc core.
- Parametrised read-port count; optional same-cycle write-to-read bypass.
- Per-register pending (scoreboard) bits, so the decode stage can stall on in-flight producers.
- Self-clearing reset sweep: every register is zeroed after reset, not left undefined.
- Sits between decode (reads, alloc) and writeback (write). A debug read port serves the simulator's GPR view and the a0/r10 trap-value check.

Parameters:
- ADDR_WIDTH, 5, register index width; depth N = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, register width in bits.
- NR_READ, 2, number of architectural read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the stored value only.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, synchronous, active-high reset.
- ready, output, 1, high once the clear sweep has finished; accesses are ignored while low.
- wen, input, 1, writeback write enable.
- waddr, input, ADDR_WIDTH, write index.
- wdata, input, DATA_WIDTH, write data.
- alloc_en, input, 1, marks alloc_addr pending (issued instruction has destination rd).
- alloc_addr, input, ADDR_WIDTH, destination index to mark pending.
- raddr, input, NR_READ*ADDR_WIDTH, packed read indices; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rdata, output, NR_READ*DATA_WIDTH, packed read data, combinational.
- rbusy, output, NR_READ, per-port flag: the source register is pending and not bypassed this cycle.
- dbg_addr, input, ADDR_WIDTH, debug read index.
- dbg_data, output, DATA_WIDTH, debug read data: stored value, never bypassed.

Behaviour:
- Reset
  - rst high at a posedge: state <= CLEAR, clr_idx <= 0, all pending bits <= 0, ready <= 0.
  - rst has priority over every other input.
- CLEAR state
  - Each cycle: rf[clr_idx] <= 0, clr_idx <= clr_idx+1.
  - At clr_idx == N-1, state <= RUN.
  - ready goes high on the cycle after the last entry is written, i.e. exactly N cycles after rst deasserts.
  - While in CLEAR: wen and alloc_en are ignored; rdata = 0, rbusy = 0, dbg_data = 0.
  - rst reasserted mid-sweep restarts the sweep from index 0.
- RUN state, writes
  - wen && waddr != 0: rf[waddr] <= wdata at posedge.
  - Writes to x0 are discarded; x0 always reads 0.
- RUN state, reads (combinational, zero latency)
  - raddr_k == 0: rdata_k = 0, rbusy_k = 0.
  - BYPASS=1 and wen && waddr == raddr_k != 0: rdata_k = wdata, rbusy_k = 0.
  - Otherwise: rdata_k = rf[raddr_k], rbusy_k = pending[raddr_k].
- Scoreboard (RUN only)
  - alloc_en && alloc_addr != 0 sets pending[alloc_addr].
  - wen && waddr != 0 clears pending[waddr].
  - Same index, same cycle: alloc wins and pending stays 1, because the newer producer owns the register. The data write still commits.
  - alloc of x0 is ignored; pending[0] is constant 0.
  - Re-alloc of an already pending register keeps it pending; there is no counting.
- Read timing
  - Reads see the pre-edge array state.
  - With BYPASS=0, a same-cycle write is visible from the next cycle only; rbusy_k still reflects the pending bit until that edge.
- Width rules
  - Indices are compared at the full ADDR_WIDTH.
  - rdata lanes are independent; no sign or zero extension is applied.

Decomposition:
- Shared package npc_pkg:
  - GPR_ADDR_W = 5, XLEN = 64, GPR_A0 = 10.
  - State encoding: CLEAR = 1'b0, RUN = 1'b1.
- One sub-module, gpr_scoreboard (params ADDR_WIDTH).
  - Holds the N pending bits and the alloc/write priority rule.
  - Exposes a pending vector.
  - gpr_file does the per-port lookup and bypass masking.

Test Plan:
1. Reset sweep: pulse rst for 1 cycle, then hold idle. Expect ready = 0 for exactly 32 cycles and 1 on cycle 33; dbg_data = 0 for all 32 indices; wen during the sweep has no effect.
2. Write/read and x0: write 0xDEAD_BEEF to r5, then 0x1234 to r0. Next cycle, raddr port0 = 5 and port1 = 0 give rdata0 = 0xDEADBEEF and rdata1 = 0; dbg_addr = 10 reads r10 correctly after a write of 0x7 to r10.
3. Bypass: BYPASS=1, wen to r7 with 0xAA while port1 reads r7, giving rdata1 = 0xAA combinationally. Rerun with BYPASS=0: same cycle gives the old value, next cycle gives 0xAA.
4. Scoreboard: alloc r3 gives rbusy = 1 on any port reading r3 the next cycle; wen r3 = 0x55 with BYPASS=1 gives rbusy = 0 that cycle; the following cycle gives pending 0 and rdata 0x55.
5. Alloc/write collision: alloc r4 and wen r4 = 0x9 in the same cycle. Next cycle, rbusy for r4 = 1 and stored value = 0x9.
6. Reset mid-operation: with r8 = 0x1 and r9 pending, assert rst. Expect ready = 0, pending cleared, the sweep restarts, and r8 reads 0 after ready rises. Reasserting rst at sweep index 20 gives a full 32-cycle restart.
